// File: rtl/rmii_pkg.sv
// rtl/rmii_pkg.sv - shared types, constants and helpers for the RMII receive path
//
// Contents:
//   rx_state_e   receive FSM states
//   PRE_DIBIT    preamble dibit (2'b01)
//   SFD_DIBIT    start-of-frame-delimiter dibit (2'b11)
//   CRC_POLY     reflected CRC-32 polynomial
//   CRC_INIT     CRC-32 preset value
//   CRC_RESIDUE  register value after a frame with a correct FCS
//   crc_step_bit one bit of reflected CRC-32
//   sat_inc16    saturating 16-bit increment

package rmii_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_EOF,
        ST_DROP
    } rx_state_e;

    localparam logic [1:0]  PRE_DIBIT   = 2'b01;
    localparam logic [1:0]  SFD_DIBIT   = 2'b11;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    function automatic logic [31:0] crc_step_bit(input logic [31:0] c, input logic b);
        return (c >> 1) ^ ({32{c[0] ^ b}} & CRC_POLY);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/eth_crc32_d2.sv
// rtl/eth_crc32_d2.sv - registered reflected CRC-32 advancing one dibit per enable
//
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (register returns to CRC_INIT)
//   init   in   synchronous preset to CRC_INIT; wins over en
//   en     in   advance the register by one dibit
//   din    in   dibit, din[0] is the earlier bit on the wire
//   crc    out  current CRC register (no final inversion)

module eth_crc32_d2
    import rmii_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic [1:0]  din,
    output logic [31:0] crc
);

    logic [31:0] crc_d;
    logic [31:0] crc_q;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = crc_step_bit(crc_step_bit(crc_q, din[0]), din[1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/rmii_rx_mac.sv
// rtl/rmii_rx_mac.sv - 100 Mb/s RMII receive MAC front end (preamble strip, CRC/length check, FCS strip)
//
// Ports:
//   CLK50        in   50 MHz RMII reference clock
//   RST_N        in   asynchronous active-low reset
//   RMII_CRS_DV  in   carrier sense / data valid
//   RMII_RXD     in   receive dibit, LSB first within a byte
//   RMII_RX_ER   in   PHY receive error
//   rx_data      out  payload byte
//   rx_valid     out  single-cycle strobe for rx_data
//   rx_sof       out  first payload byte of a frame (with rx_valid)
//   rx_eof       out  single-cycle end-of-frame strobe
//   rx_good      out  frame status, valid with rx_eof
//   frames_ok    out  saturating good-frame count
//   frames_bad   out  saturating bad-frame count

module rmii_rx_mac
    import rmii_pkg::*;
#(
    parameter int MAX_FRAME = 1522,
    parameter int MIN_FRAME = 64
) (
    input  logic        CLK50,
    input  logic        RST_N,
    input  logic        RMII_CRS_DV,
    input  logic [1:0]  RMII_RXD,
    input  logic        RMII_RX_ER,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_good,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_bad
);

    localparam logic [10:0] MAX_B = 11'(MAX_FRAME);
    localparam logic [10:0] MIN_B = 11'(MIN_FRAME);

    rx_state_e   state_q, state_d;
    logic        armed_q, armed_d;
    logic        crs_prev_q, crs_prev_d;
    logic [1:0]  rxd_prev_q, rxd_prev_d;
    logic        first_q, first_d;
    logic [7:0]  sh_q, sh_d;
    logic [1:0]  dcnt_q, dcnt_d;
    logic [10:0] bcnt_q, bcnt_d;
    logic [31:0] dl_q, dl_d;
    logic        err_rx_q, err_rx_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_sof_q, rx_sof_d;
    logic        rx_eof_q, rx_eof_d;
    logic        rx_good_q, rx_good_d;
    logic [15:0] frames_ok_q, frames_ok_d;
    logic [15:0] frames_bad_q, frames_bad_d;

    logic        crc_init;
    logic        crc_en;
    logic [31:0] crc_val;
    logic        push_prev;
    logic        push_cur;
    logic [7:0]  asm_sh;
    logic [1:0]  asm_dc;
    logic        byte_done;
    logic [7:0]  byte_val;
    logic [10:0] byte_n;
    logic        frame_good;

    // The CRC runs one dibit behind the wire: a dibit is folded in on the
    // edge after it was sampled, once its CRS_DV (or the following one) has
    // confirmed it as frame data. This keeps it at one dibit per cycle even
    // when a deferred low-CRS_DV dibit is released together with the next one.
    eth_crc32_d2 u_crc (
        .clk   (CLK50),
        .rst_n (RST_N),
        .init  (crc_init),
        .en    (crc_en),
        .din   (rxd_prev_q),
        .crc   (crc_val)
    );

    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        crs_prev_d   = RMII_CRS_DV;
        rxd_prev_d   = RMII_RXD;
        first_d      = 1'b0;
        sh_d         = sh_q;
        dcnt_d       = dcnt_q;
        bcnt_d       = bcnt_q;
        dl_d         = dl_q;
        err_rx_d     = err_rx_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        rx_sof_d     = 1'b0;
        rx_eof_d     = 1'b0;
        rx_good_d    = 1'b0;
        frames_ok_d  = frames_ok_q;
        frames_bad_d = frames_bad_q;
        crc_init     = 1'b0;
        crc_en       = 1'b0;
        push_prev    = 1'b0;
        push_cur     = 1'b0;
        asm_sh       = sh_q;
        asm_dc       = dcnt_q;
        byte_done    = 1'b0;
        byte_val     = 8'h00;
        byte_n       = bcnt_q + 11'd1;
        frame_good   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!RMII_CRS_DV) begin
                    armed_d = 1'b1;
                end else if (armed_q && (RMII_RXD == PRE_DIBIT)) begin
                    state_d = ST_PREAMBLE;
                end
            end

            ST_PREAMBLE: begin
                if (!RMII_CRS_DV) begin
                    state_d = ST_IDLE;
                    armed_d = 1'b1;
                end else if (RMII_RXD == SFD_DIBIT) begin
                    state_d  = ST_DATA;
                    first_d  = 1'b1;
                    dcnt_d   = 2'd0;
                    bcnt_d   = 11'd0;
                    err_rx_d = 1'b0;
                    crc_init = 1'b1;
                end else if (RMII_RXD == 2'b10) begin
                    state_d = ST_DROP;
                end
            end

            ST_DATA: begin
                err_rx_d = err_rx_q | RMII_RX_ER;
                // rxd_prev_q still holds the SFD dibit on the first DATA edge
                crc_en   = !first_q && (crs_prev_q || RMII_CRS_DV);

                if (!RMII_CRS_DV && !crs_prev_q) begin
                    // Second consecutive low: both low-CRS_DV dibits are dropped.
                    frame_good = (dcnt_q == 2'd0) && (bcnt_q >= MIN_B) && (bcnt_q <= MAX_B) &&
                                 !(err_rx_q || RMII_RX_ER) && (crc_val == CRC_RESIDUE);
                    rx_eof_d  = 1'b1;
                    rx_good_d = frame_good;
                    if (frame_good) begin
                        frames_ok_d = sat_inc16(frames_ok_q);
                    end else begin
                        frames_bad_d = sat_inc16(frames_bad_q);
                    end
                    state_d = ST_EOF;
                end else if (RMII_CRS_DV) begin
                    // A dibit sampled with CRS_DV low is only assembled once the
                    // next sample shows carrier again.
                    push_prev = !crs_prev_q;
                    push_cur  = 1'b1;
                end

                if (push_prev) begin
                    asm_sh = {rxd_prev_q, asm_sh[7:2]};
                    if (asm_dc == 2'd3) begin
                        byte_done = 1'b1;
                        byte_val  = asm_sh;
                    end
                    asm_dc = asm_dc + 2'd1;
                end
                if (push_cur) begin
                    asm_sh = {RMII_RXD, asm_sh[7:2]};
                    if (asm_dc == 2'd3) begin
                        byte_done = 1'b1;
                        byte_val  = asm_sh;
                    end
                    asm_dc = asm_dc + 2'd1;
                end
                sh_d   = asm_sh;
                dcnt_d = asm_dc;

                if (byte_done) begin
                    if (byte_n > MAX_B) begin
                        rx_eof_d     = 1'b1;
                        rx_good_d    = 1'b0;
                        frames_bad_d = sat_inc16(frames_bad_q);
                        state_d      = ST_DROP;
                    end else begin
                        bcnt_d = byte_n;
                        // Four-byte delay line: the oldest byte leaves only when a
                        // fifth arrives, so the trailing FCS is never emitted.
                        dl_d   = {byte_val, dl_q[31:8]};
                        if (byte_n >= 11'd5) begin
                            rx_valid_d = 1'b1;
                            rx_data_d  = dl_q[7:0];
                            rx_sof_d   = (byte_n == 11'd5);
                        end
                    end
                end
            end

            ST_EOF: begin
                state_d = ST_IDLE;
            end

            ST_DROP: begin
                if (!RMII_CRS_DV && !crs_prev_q) begin
                    state_d = ST_IDLE;
                    armed_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK50 or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            armed_q      <= 1'b0;
            crs_prev_q   <= 1'b0;
            rxd_prev_q   <= 2'b00;
            first_q      <= 1'b0;
            sh_q         <= 8'h00;
            dcnt_q       <= 2'd0;
            bcnt_q       <= 11'd0;
            dl_q         <= 32'h0;
            err_rx_q     <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            rx_sof_q     <= 1'b0;
            rx_eof_q     <= 1'b0;
            rx_good_q    <= 1'b0;
            frames_ok_q  <= 16'h0;
            frames_bad_q <= 16'h0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            crs_prev_q   <= crs_prev_d;
            rxd_prev_q   <= rxd_prev_d;
            first_q      <= first_d;
            sh_q         <= sh_d;
            dcnt_q       <= dcnt_d;
            bcnt_q       <= bcnt_d;
            dl_q         <= dl_d;
            err_rx_q     <= err_rx_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_sof_q     <= rx_sof_d;
            rx_eof_q     <= rx_eof_d;
            rx_good_q    <= rx_good_d;
            frames_ok_q  <= frames_ok_d;
            frames_bad_q <= frames_bad_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_sof     = rx_sof_q;
    assign rx_eof     = rx_eof_q;
    assign rx_good    = rx_good_q;
    assign frames_ok  = frames_ok_q;
    assign frames_bad = frames_bad_q;

endmodule

// File: tb/tb_rmii_rx_mac.sv
// tb/tb_rmii_rx_mac.sv - directed self-checking bench for rmii_rx_mac

module tb_rmii_rx_mac;

    logic        CLK50 = 1'b0;
    logic        RST_N = 1'b0;
    logic        RMII_CRS_DV = 1'b0;
    logic [1:0]  RMII_RXD = 2'b00;
    logic        RMII_RX_ER = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sof;
    logic        rx_eof;
    logic        rx_good;
    logic [15:0] frames_ok;
    logic [15:0] frames_bad;

    rmii_rx_mac #(.MAX_FRAME(1522), .MIN_FRAME(64)) dut (
        .CLK50       (CLK50),
        .RST_N       (RST_N),
        .RMII_CRS_DV (RMII_CRS_DV),
        .RMII_RXD    (RMII_RXD),
        .RMII_RX_ER  (RMII_RX_ER),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_sof      (rx_sof),
        .rx_eof      (rx_eof),
        .rx_good     (rx_good),
        .frames_ok   (frames_ok),
        .frames_bad  (frames_bad)
    );

    always #10 CLK50 = ~CLK50;

    int cyc = 0;
    always @(posedge CLK50) cyc <= cyc + 1;

    // output monitor, sampled on the falling edge
    logic [7:0] rcv [0:8191];
    int n_rx = 0, sof_cnt = 0, sof_idx = 0, sof_cyc = 0;
    int eof_cnt = 0, eof_cyc = 0, clash = 0;
    logic last_good = 1'b0;

    always @(negedge CLK50) begin
        if (rx_valid) begin
            if (n_rx < 8192) rcv[n_rx] <= rx_data;
            n_rx <= n_rx + 1;
            if (rx_sof) begin
                sof_cnt <= sof_cnt + 1;
                sof_idx <= n_rx;
                sof_cyc <= cyc;
            end
        end
        if (rx_eof) begin
            eof_cnt   <= eof_cnt + 1;
            last_good <= rx_good;
            eof_cyc   <= cyc;
        end
        if ((rx_eof && rx_valid) || (rx_sof && !rx_valid)) clash <= clash + 1;
    end

    // dibit stream to play
    logic [1:0] s_d [0:8191];
    logic       s_c [0:8191];
    logic       s_e [0:8191];
    int s_len = 0;
    int t0 = 0;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++) begin
            if (r[0] ^ b[k]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic push(input logic c, input logic [1:0] d);
        s_c[s_len] = c;
        s_d[s_len] = d;
        s_e[s_len] = 1'b0;
        s_len++;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) push(1'b1, b[2*k +: 2]);
    endtask

    // npl payload bytes 0,1,2.. plus correct FCS; optional bit flip, RX_ER,
    // single-cycle CRS_DV drop (data-dibit indices) and trailing dibits
    task automatic build(input int npl, input int flip, input int er_at,
                         input int glitch_at, input int extra);
        logic [31:0] c;
        logic [7:0]  b;
        s_len = 0;
        for (int i = 0; i < 7; i++) push_byte(8'h55);
        push_byte(8'hD5);
        c = 32'hFFFFFFFF;
        for (int i = 0; i < npl; i++) begin
            b = i[7:0];
            c = crc_byte(c, b);
            if (i == flip) b[0] = ~b[0];
            push_byte(b);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) push_byte(c[8*i +: 8]);
        for (int i = 0; i < extra; i++) push(1'b1, 2'b10);
        if (er_at >= 0) s_e[32 + er_at] = 1'b1;
        if (glitch_at >= 0) s_c[32 + glitch_at] = 1'b0;
        for (int i = 0; i < 6; i++) push(1'b0, 2'b00);
    endtask

    task automatic play(input int from, input int to);
        for (int i = from; i <= to; i++) begin
            @(negedge CLK50);
            if (i == from) t0 = cyc;
            RMII_CRS_DV = s_c[i];
            RMII_RXD    = s_d[i];
            RMII_RX_ER  = s_e[i];
        end
        repeat (2) @(posedge CLK50);
        @(negedge CLK50);
    endtask

    int bn, be, bs, bad;

    initial begin
        // reset state
        repeat (3) @(posedge CLK50);
        #3;
        check("rst_data",  32'(rx_data), 32'h0);
        check("rst_valid", 32'(rx_valid), 32'h0);
        check("rst_sof",   32'(rx_sof), 32'h0);
        check("rst_eof",   32'(rx_eof), 32'h0);
        check("rst_good",  32'(rx_good), 32'h0);
        check("rst_ok",    32'(frames_ok), 32'h0);
        check("rst_bad",   32'(frames_bad), 32'h0);
        @(negedge CLK50);
        RST_N = 1'b1;
        repeat (4) @(negedge CLK50);

        // good frame with a one-cycle CRS_DV drop inside byte 25
        bn = n_rx; be = eof_cnt; bs = sof_cnt;
        build(60, -1, -1, 101, 0);
        play(0, s_len - 1);
        check("good_n",    32'(n_rx - bn), 32'd60);
        bad = 0;
        for (int i = 0; i < 60; i++) if (rcv[bn + i] !== i[7:0]) bad++;
        check("good_payload", 32'(bad), 32'd0);
        check("good_sofcnt", 32'(sof_cnt - bs), 32'd1);
        check("good_sofidx", 32'(sof_idx), 32'(bn));
        check("good_lat",  32'(sof_cyc - t0), 32'd52);
        check("good_eofcnt", 32'(eof_cnt - be), 32'd1);
        check("good_eofcyc", 32'(eof_cyc - t0), 32'd290);
        check("good_rxgood", 32'(last_good), 32'd1);
        check("good_ok",   32'(frames_ok), 32'd1);
        check("good_bad",  32'(frames_bad), 32'd0);

        // CRC error: bit 0 of byte 0x10 flipped on the wire
        bn = n_rx; be = eof_cnt;
        build(60, 16, -1, -1, 0);
        play(0, s_len - 1);
        check("crc_n",     32'(n_rx - bn), 32'd60);
        check("crc_byte",  32'(rcv[bn + 16]), 32'h11);
        check("crc_eofcnt", 32'(eof_cnt - be), 32'd1);
        check("crc_rxgood", 32'(last_good), 32'd0);
        check("crc_bad",   32'(frames_bad), 32'd1);
        check("crc_ok",    32'(frames_ok), 32'd1);

        // RX_ER during byte 20
        bn = n_rx; be = eof_cnt;
        build(60, -1, 80, -1, 0);
        play(0, s_len - 1);
        check("rxer_n",    32'(n_rx - bn), 32'd60);
        check("rxer_eofcnt", 32'(eof_cnt - be), 32'd1);
        check("rxer_rxgood", 32'(last_good), 32'd0);
        check("rxer_bad",  32'(frames_bad), 32'd2);

        // runt: 60 bytes including FCS
        bn = n_rx; be = eof_cnt;
        build(56, -1, -1, -1, 0);
        play(0, s_len - 1);
        check("runt_n",    32'(n_rx - bn), 32'd56);
        check("runt_eofcnt", 32'(eof_cnt - be), 32'd1);
        check("runt_rxgood", 32'(last_good), 32'd0);
        check("runt_bad",  32'(frames_bad), 32'd3);

        // good 64-byte frame plus one trailing dibit
        bn = n_rx; be = eof_cnt;
        build(60, -1, -1, -1, 1);
        play(0, s_len - 1);
        check("mis_n",     32'(n_rx - bn), 32'd60);
        check("mis_eofcnt", 32'(eof_cnt - be), 32'd1);
        check("mis_rxgood", 32'(last_good), 32'd0);
        check("mis_bad",   32'(frames_bad), 32'd4);

        // 1600-byte frame: abort when byte 1523 completes
        bn = n_rx; be = eof_cnt;
        build(1596, -1, -1, -1, 0);
        play(0, s_len - 1);
        check("long_n",    32'(n_rx - bn), 32'd1518);
        check("long_last", 32'(rcv[bn + 1517]), 32'hED);
        check("long_eofcnt", 32'(eof_cnt - be), 32'd1);
        check("long_eofcyc", 32'(eof_cyc - t0), 32'd6124);
        check("long_rxgood", 32'(last_good), 32'd0);
        check("long_bad",  32'(frames_bad), 32'd5);
        check("long_ok",   32'(frames_ok), 32'd1);

        // reset asserted at byte 30, released while carrier is still up
        build(60, -1, -1, -1, 0);
        for (int i = 0; i <= 151; i++) begin
            @(negedge CLK50);
            RMII_CRS_DV = s_c[i];
            RMII_RXD    = s_d[i];
            RMII_RX_ER  = s_e[i];
        end
        @(posedge CLK50);
        #2 RST_N = 1'b0;
        #1;
        check("mrst_valid", 32'(rx_valid), 32'h0);
        check("mrst_data",  32'(rx_data), 32'h0);
        check("mrst_sof",   32'(rx_sof), 32'h0);
        check("mrst_eof",   32'(rx_eof), 32'h0);
        check("mrst_good",  32'(rx_good), 32'h0);
        check("mrst_ok",    32'(frames_ok), 32'h0);
        check("mrst_bad",   32'(frames_bad), 32'h0);
        bn = n_rx; be = eof_cnt;
        @(negedge CLK50);
        RMII_CRS_DV = s_c[152];
        RMII_RXD    = s_d[152];
        @(negedge CLK50);
        RST_N       = 1'b1;
        RMII_CRS_DV = s_c[153];
        RMII_RXD    = s_d[153];
        play(154, s_len - 1);
        check("mrst_rest_n",   32'(n_rx - bn), 32'd0);
        check("mrst_rest_eof", 32'(eof_cnt - be), 32'd0);
        check("mrst_rest_cnt", 32'({frames_ok, frames_bad}), 32'h0);

        // next good frame after the reset
        bn = n_rx; be = eof_cnt;
        build(60, -1, -1, -1, 0);
        play(0, s_len - 1);
        check("post_n",      32'(n_rx - bn), 32'd60);
        check("post_eofcnt", 32'(eof_cnt - be), 32'd1);
        check("post_rxgood", 32'(last_good), 32'd1);
        check("post_ok",     32'(frames_ok), 32'd1);
        check("post_bad",    32'(frames_bad), 32'd0);
        check("no_clash",    32'(clash), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
